// File: rtl/axis_histogram_reader_if.sv
// AXI4-Stream master beat channel plus the BRAM port-B signals used by the histogram reader.
// The reader drives through the master modport; the stream sink / BRAM model use slave.
interface axis_histogram_reader_if #(
    parameter int DW = 32,
    parameter int AW = 14
);
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic            m_axis_tready;

    logic            b_bram_clk;
    logic            b_bram_rst;
    logic            b_bram_en;
    logic [DW/8-1:0] b_bram_we;
    logic [AW-1:0]   b_bram_addr;
    logic [DW-1:0]   b_bram_wdata;
    logic [DW-1:0]   b_bram_rdata;

    modport master (
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready,
        output b_bram_clk, b_bram_rst, b_bram_en, b_bram_we, b_bram_addr, b_bram_wdata,
        input  b_bram_rdata
    );

    modport slave (
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready,
        input  b_bram_clk, b_bram_rst, b_bram_en, b_bram_we, b_bram_addr, b_bram_wdata,
        output b_bram_rdata
    );
endinterface

// File: rtl/axis_histogram_reader.sv
// Streams histogram bins 0..cfg_last_addr from BRAM port B onto AXI4-Stream, one beat per bin.
// Define HIST_CLEAR_EN to zero each bin right after its beat is accepted.
module axis_histogram_reader #(
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH = 14
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       start,
    input  logic [BRAM_ADDR_WIDTH-1:0] cfg_last_addr,
    output logic                       busy,
    output logic                       done,
    axis_histogram_reader_if.master    bus
);
    localparam int DW  = BRAM_DATA_WIDTH;
    localparam int AW  = BRAM_ADDR_WIDTH;
    localparam int WEW = DW / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
`ifdef HIST_CLEAR_EN
        S_TX,
        S_CLR
`else
        S_TX
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [AW-1:0] last_q,  last_d;
    logic [DW-1:0] tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;
    logic          en_q,    en_d;
    logic [AW-1:0] baddr_q, baddr_d;
`ifdef HIST_CLEAR_EN
    logic [WEW-1:0] we_q, we_d;
`endif

    logic hs;
    logic at_last;

    assign hs      = tvalid_q & bus.m_axis_tready;
    assign at_last = (addr_q == last_q);

    // State register
    always_ff @(posedge aclk) begin
        if (areset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RD;
            S_RD:   state_d = S_CAP;
            S_CAP:  state_d = S_TX;
            S_TX: begin
                if (hs) begin
`ifdef HIST_CLEAR_EN
                    state_d = S_CLR;
`else
                    state_d = at_last ? S_IDLE : S_RD;
`endif
                end
            end
`ifdef HIST_CLEAR_EN
            S_CLR:  state_d = at_last ? S_IDLE : S_RD;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values; every port output is registered, so each
    // one is computed from the state being entered rather than the current one.
    always_comb begin
        addr_d   = addr_q;
        last_d   = last_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_IDLE) && (state_q != S_IDLE);

        if (state_q == S_IDLE && start) begin
            last_d = cfg_last_addr;
            addr_d = '0;
        end

        if (state_q == S_CAP) begin
            tdata_d  = bus.b_bram_rdata;
            tvalid_d = 1'b1;
            tlast_d  = at_last;
        end

        if (state_q == S_TX && hs) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        // Advance only when heading back for another bin; the top bin never wraps.
        if (state_q != S_IDLE && state_q != S_RD && state_d == S_RD)
            addr_d = addr_q + 1'b1;

`ifdef HIST_CLEAR_EN
        en_d = (state_d == S_RD) || (state_d == S_CLR);
        we_d = (state_d == S_CLR) ? {WEW{1'b1}} : '0;
`else
        en_d = (state_d == S_RD);
`endif
        baddr_d = en_d ? addr_d : baddr_q;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            addr_q   <= '0;
            last_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            en_q     <= 1'b0;
            baddr_q  <= '0;
`ifdef HIST_CLEAR_EN
            we_q     <= '0;
`endif
        end else begin
            addr_q   <= addr_d;
            last_q   <= last_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            en_q     <= en_d;
            baddr_q  <= baddr_d;
`ifdef HIST_CLEAR_EN
            we_q     <= we_d;
`endif
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tlast  = tlast_q;
    assign bus.b_bram_clk    = aclk;
    assign bus.b_bram_rst    = areset;
    assign bus.b_bram_en     = en_q;
    assign bus.b_bram_addr   = baddr_q;
    assign bus.b_bram_wdata  = '0;
`ifdef HIST_CLEAR_EN
    assign bus.b_bram_we     = we_q;
`else
    assign bus.b_bram_we     = '0;
`endif

`ifndef SYNTHESIS
    a_stall_stable: assert property (@(posedge aclk) disable iff (areset)
        (tvalid_q && !bus.m_axis_tready) |=> (tvalid_q && $stable(tdata_q) && $stable(tlast_q)));
    a_no_bram_in_tx: assert property (@(posedge aclk) disable iff (areset)
        (state_q == S_TX) |-> !en_q);
`endif
endmodule

// File: tb/tb_axis_histogram_reader.sv
// Bench for axis_histogram_reader: BRAM model, table-driven dumps, random dumps and hand-written corner sequences.
// Expected beats come from a bin array updated with the clear-after-send rule.
module tb_axis_histogram_reader;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NB = 1 << AW;
`ifdef HIST_CLEAR_EN
    localparam bit CLEAR = 1'b1;
`else
    localparam bit CLEAR = 1'b0;
`endif
    localparam int PER    = CLEAR ? 4 : 3;
    localparam int BUDGET = 2000;

    logic          aclk = 1'b0;
    logic          areset;
    logic          start;
    logic [AW-1:0] cfg;
    logic          busy, done;

    axis_histogram_reader_if #(.DW(DW), .AW(AW)) bus ();

    axis_histogram_reader #(.BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .cfg_last_addr (cfg),
        .busy          (busy),
        .done          (done),
        .bus           (bus)
    );

    always #5 aclk = ~aclk;

    // Port-B BRAM: read-first, one-cycle read latency, byte write enables.
    logic [DW-1:0] bram [NB];
    always @(posedge aclk) begin
        if (bus.b_bram_en) begin
            for (int b = 0; b < DW/8; b++)
                if (bus.b_bram_we[b]) bram[bus.b_bram_addr][8*b +: 8] <= bus.b_bram_wdata[8*b +: 8];
            bus.b_bram_rdata <= bram[bus.b_bram_addr];
        end
    end

    logic [DW-1:0] ref_bins [NB];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_bin(input int i, input logic [DW-1:0] v);
        bram[i] <= v;
        ref_bins[i] = v;
    endtask

    task automatic start_dump(input int last);
        @(negedge aclk);
        start = 1'b1;
        cfg   = AW'(last);
    endtask

    // Runs one dump whose start was driven at the previous negedge.
    task automatic run_body(input int last, input int stall_beat, input int stall_len,
                            input bit rnd, input bit hold, input bit guard,
                            input int rst_beat, input int exp_beats, input int exp_lat);
        logic [DW-1:0] exp_q[$];
        int beat = 0, stall_cnt = 0, hs_k = 0;
        bit fin = 0, seen_valid = 0, prev_stalled = 0, r, ok;
        logic [DW-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        for (int i = 0; i <= last; i++) exp_q.push_back(ref_bins[i]);
        for (int k = 1; k <= BUDGET && !fin; k++) begin
            @(negedge aclk);
            if (k == 1) begin
                start = hold;
                chk("start_busy", busy, 1);
                chk("start_rd_en", bus.b_bram_en, 1);
                chk("start_addr0", bus.b_bram_addr, 0);
            end
            if (guard && k == 4) begin start = 1'b1; cfg = AW'(1); end
            if (guard && k == 5) start = 1'b0;
            if (bus.b_bram_en === 1'b1) begin
                ok = (bus.b_bram_we == '0) ||
                     (CLEAR && bus.b_bram_we == '1 && bus.b_bram_wdata == '0);
                chk("bram_write_legal", ok, 1);
            end
            if (done) begin
                chk("done_beats", beat, exp_beats);
                chk("done_after_hs", k, hs_k + (CLEAR ? 2 : 1));
                chk("done_busy_low", busy, 0);
                chk("done_tvalid_low", bus.m_axis_tvalid, 0);
                fin = 1;
            end else if (bus.m_axis_tvalid) begin
                if (!seen_valid) begin
                    seen_valid = 1;
                    chk("first_tvalid_latency", k, exp_lat);
                end
                chk("tx_bram_idle", bus.b_bram_en, 0);
                if (prev_stalled) begin
                    chk("stall_tdata_stable", bus.m_axis_tdata, prev_data);
                    chk("stall_tlast_stable", bus.m_axis_tlast, prev_last);
                end
                if (rst_beat >= 0 && beat == rst_beat) begin
                    bus.m_axis_tready = 1'b0;
                    areset = 1'b1;
                    @(negedge aclk);
                    chk("rst_tvalid", bus.m_axis_tvalid, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_done", done, 0);
                    chk("rst_en", bus.b_bram_en, 0);
                    areset = 1'b0;
                    start = 1'b0;
                    if (CLEAR) for (int i = 0; i < beat; i++) ref_bins[i] = '0;
                    bus.m_axis_tready = 1'b1;
                    return;
                end
                if (beat == stall_beat && stall_cnt < stall_len) begin
                    r = 1'b0;
                    stall_cnt++;
                end else begin
                    r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                bus.m_axis_tready = r;
                if (r) begin
                    chk("beat_tdata", bus.m_axis_tdata, (beat < exp_q.size()) ? exp_q[beat] : 'x);
                    chk("beat_tlast", bus.m_axis_tlast, (beat == last) ? 1 : 0);
                    if (!rnd && stall_len == 0) chk("beat_spacing", k, exp_lat + PER * beat);
                    hs_k = k;
                    beat++;
                    prev_stalled = 0;
                end else begin
                    prev_stalled = 1;
                    prev_data = bus.m_axis_tdata;
                    prev_last = bus.m_axis_tlast;
                end
            end else begin
                chk("busy_mid_dump", busy, 1);
                bus.m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        chk("dump_completed", fin, 1);
        if (!hold) start = 1'b0;
        bus.m_axis_tready = 1'b1;
        if (CLEAR) for (int i = 0; i < beat; i++) ref_bins[i] = '0;
    endtask

    typedef struct {
        int pat;        // 0: {10,20,30,40}  1: bin i = i+1  2: bin0 = 7
        int last;
        int stall_beat;
        int stall_len;
        int exp_beats;
        int exp_lat;
    } vec_t;
    vec_t vecs[4];

    task automatic load_pat(input int pat);
        for (int i = 0; i < NB; i++) begin
            case (pat)
                0:       load_bin(i, (i < 4) ? DW'(10 * (i + 1)) : DW'(32'hdead0000 + i));
                1:       load_bin(i, DW'(i + 1));
                default: load_bin(i, (i == 0) ? DW'(7) : DW'(32'hbeef0000 + i));
            endcase
        end
    endtask

    initial begin
        areset = 1'b1;
        start  = 1'b0;
        cfg    = '0;
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i < NB; i++) load_bin(i, '0);
        repeat (3) @(negedge aclk);
        chk("rst_tvalid0", bus.m_axis_tvalid, 0);
        chk("rst_tlast0",  bus.m_axis_tlast, 0);
        chk("rst_tdata0",  bus.m_axis_tdata, 0);
        chk("rst_busy0",   busy, 0);
        chk("rst_done0",   done, 0);
        chk("rst_en0",     bus.b_bram_en, 0);
        chk("rst_we0",     bus.b_bram_we, 0);
        chk("rst_addr0",   bus.b_bram_addr, 0);
        chk("rst_bram_rst", bus.b_bram_rst, 1);
        areset = 1'b0;

        vecs[0] = '{pat: 0, last: 3,  stall_beat: -1, stall_len: 0, exp_beats: 4,  exp_lat: 3};
        vecs[1] = '{pat: 0, last: 3,  stall_beat: 1,  stall_len: 5, exp_beats: 4,  exp_lat: 3};
        vecs[2] = '{pat: 2, last: 0,  stall_beat: -1, stall_len: 0, exp_beats: 1,  exp_lat: 3};
        vecs[3] = '{pat: 1, last: 15, stall_beat: -1, stall_len: 0, exp_beats: 16, exp_lat: 3};
        for (int v = 0; v < 4; v++) begin
            @(negedge aclk);
            load_pat(vecs[v].pat);
            start_dump(vecs[v].last);
            run_body(vecs[v].last, vecs[v].stall_beat, vecs[v].stall_len, 1'b0, 1'b0, 1'b0, -1,
                     vecs[v].exp_beats, vecs[v].exp_lat);
            @(negedge aclk);
            chk("idle_after_done_busy", busy, 0);
            chk("idle_after_done_pulse", done, 0);
        end

        // Random bins, random last address, random ready.
        for (int n = 0; n < 6; n++) begin
            int last;
            @(negedge aclk);
            for (int i = 0; i < NB; i++) load_bin(i, DW'($urandom));
            last = $urandom_range(0, NB - 1);
            start_dump(last);
            run_body(last, -1, 0, 1'b1, 1'b0, 1'b0, -1, last + 1, 3);
        end

        // Start/cfg changes while busy are ignored; reset while beat 2 is presented.
        @(negedge aclk);
        load_pat(0);
        start_dump(3);
        run_body(3, -1, 0, 1'b0, 1'b0, 1'b1, 2, 4, 3);
        start_dump(3);
        run_body(3, -1, 0, 1'b0, 1'b0, 1'b0, -1, 4, 3);

        // Start held high: a second dump begins right after done.
        @(negedge aclk);
        load_pat(0);
        start_dump(3);
        run_body(3, -1, 0, 1'b0, 1'b1, 1'b0, -1, 4, 3);
        run_body(3, -1, 0, 1'b0, 1'b0, 1'b0, -1, 4, 3);

        // Clear-after-send: a second dump sees zeros only when clearing is built in.
        @(negedge aclk);
        for (int i = 0; i < 4; i++) load_bin(i, DW'(5 + i));
        start_dump(3);
        run_body(3, -1, 0, 1'b0, 1'b0, 1'b0, -1, 4, 3);
        start_dump(3);
        run_body(3, -1, 0, 1'b0, 1'b0, 1'b0, -1, 4, 3);
        @(negedge aclk);
        chk("bin0_after_dumps", bram[0], CLEAR ? 0 : 5);
        chk("bin3_after_dumps", bram[3], CLEAR ? 0 : 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
